// File: rtl/math_seq_unit.sv
// math_seq_unit
//   Iterative run-time math helper: ceiling log2, clamped log2 (clog2-1),
//   and ceiling word-count division. One operation in flight at a time.
//   Each operation spends DATA_W iteration cycles plus one finalize cycle
//   in CALC, so out_valid rises DATA_W+1 edges after the accept edge.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready is registered)
//   in_op          0=CLOG2, 1=CLOG2_RANGE, 2=WORD_COUNT, 3=reserved
//   in_a, in_b     unsigned operands (in_b used by WORD_COUNT only)
//   out_valid/out_ready result handshake
//   out_result, out_err  result and error flag, stable while in DONE
//   busy           high while in CALC or DONE
module math_seq_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  localparam logic [1:0] OP_CLOG2 = 2'd0;
  localparam logic [1:0] OP_RANGE = 2'd1;
  localparam logic [1:0] OP_WC    = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_acc;   // CLOG2: shifting copy of a-1; WORD_COUNT: dividend/quotient
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rem;   // divider partial remainder, always < r_b
  logic [DATA_W-1:0] r_res;   // CLOG2: 1 + index of highest set bit seen so far
  logic [CW-1:0]     r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_err;
  logic              r_busy;

  logic [DATA_W:0]   w_trial;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_cnt_p1;
  logic [DATA_W-1:0] w_final;
  logic              w_final_err;

  // Restoring divider step: shift next dividend bit into the remainder and
  // subtract the divisor when it fits. The true difference is < r_b, so the
  // DATA_W-bit wraparound subtraction is exact.
  always_comb begin
    w_trial   = {r_rem, r_acc[DATA_W-1]};
    w_ge      = (w_trial >= {1'b0, r_b});
    w_rem_nxt = w_ge ? (w_trial[DATA_W-1:0] - r_b) : w_trial[DATA_W-1:0];
    w_cnt_p1  = DATA_W'(r_cnt) + DATA_W'(1);
  end

  always_comb begin
    w_final     = '0;
    w_final_err = 1'b0;
    case (r_op)
      OP_CLOG2: w_final = r_res;
      OP_RANGE: w_final = (r_res == '0) ? '0 : r_res - DATA_W'(1);
      OP_WC: begin
        if (r_b == '0) begin
          w_final     = '1;
          w_final_err = 1'b1;
        end else begin
          // a non-zero remainder implies b>=2, so the +1 cannot overflow
          w_final = r_acc + DATA_W'(r_rem != '0);
        end
      end
      default: w_final_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_acc        <= '0;
      r_b          <= '0;
      r_rem        <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_op       <= in_op;
            r_b        <= in_b;
            r_rem      <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            // a=0 scans as v=0 so clog2(0)=0 rather than wrapping to all ones
            if (in_op == OP_WC)  r_acc <= in_a;
            else if (in_a == '0) r_acc <= '0;
            else                 r_acc <= in_a - DATA_W'(1);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt == LAST) begin
            r_out_result <= w_final;
            r_out_err    <= w_final_err;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op == OP_WC) begin
              r_acc <= {r_acc[DATA_W-2:0], w_ge};
              r_rem <= w_rem_nxt;
            end else begin
              // LSB-first scan: the last set bit seen is the highest one
              if (r_acc[0]) r_res <= w_cnt_p1;
              r_acc <= r_acc >> 1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_err    = r_out_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_math_seq_unit.sv
module tb_math_seq_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DATA_W = 32 instance
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_err;
  logic        busy;

  math_seq_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy));

  // DATA_W = 8 instance
  logic        rst8 = 1'b1;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [1:0]  in_op8 = '0;
  logic [7:0]  in_a8 = '0, in_b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  out_result8;
  logic        out_err8;
  logic        busy8;

  math_seq_unit #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
    .in_a(in_a8), .in_b(in_b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8), .out_err(out_err8), .busy(busy8));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model from the arithmetic definitions (64-bit, no overflow).
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint unsigned n = 0;
    longint unsigned aa = 64'(a);
    longint unsigned bb = 64'(b);
    while ((64'd1 << n) < aa) n++;
    r = '0; e = 1'b0;
    case (op)
      2'd0: r = 32'(n);
      2'd1: r = (n > 0) ? 32'(n - 1) : 32'd0;
      2'd2: if (bb == 0) begin r = '1; e = 1'b1; end
            else r = 32'((aa + bb - 1) / bb);
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Drives one request and collects the result; latency counted in edges
  // from the accept edge to the first edge after which out_valid is high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic err, output int lat, output bit ok);
    int w = 0;
    ok = 1'b1;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (lat >= 200) ok = 1'b0;
    res = out_result; err = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, busy, in_ready, out_err} !== 4'b0000 || out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b err=%b res=%h, want all 0",
               out_valid, busy, in_ready, out_err, out_result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [20];
    logic [31:0] as  [20];
    logic [31:0] bs  [20];
    logic [31:0] exp_r [20];
    logic        exp_e [20];
    logic [31:0] r; logic e; int lat; bit ok;
    ops = '{0,0,0,0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2};
    as  = '{0,1,2,3,5,1024,1025,32'hFFFFFFFF, 0,1,2,3,1024,32'h80000001,
            100,96,0,32'hFFFFFFFF,32'hFFFFFFFF,33};
    bs  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 32,32,7,1,32'hFFFFFFFF,2};
    exp_r = '{0,0,1,2,3,10,11,32, 0,0,0,1,9,31, 4,3,0,32'hFFFFFFFF,1,17};
    exp_e = '{default: 1'b0};
    for (int i = 0; i < 20; i++) begin
      run_op(ops[i], as[i], bs[i], r, e, lat, ok);
      n_tests++;
      if (!ok || r !== exp_r[i] || e !== exp_e[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h: got res=%h err=%b ok=%b, want res=%h err=%b",
                 i, ops[i], as[i], bs[i], r, e, ok, exp_r[i], exp_e[i]);
      end
      n_tests++;
      if (lat !== 33) begin
        n_fail++; $display("FAIL latency[%0d]: got %0d want 33", i, lat);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat; bit ok;
    run_op(2'd2, 32'd5, 32'd0, r, e, lat, ok);
    n_tests++;
    if (!ok || r !== 32'hFFFFFFFF || e !== 1'b1 || lat !== 33) begin
      n_fail++; $display("FAIL div_by_zero: got res=%h err=%b lat=%0d, want ffffffff 1 33", r, e, lat);
    end
    run_op(2'd3, 32'd77, 32'd3, r, e, lat, ok);
    n_tests++;
    if (!ok || r !== 32'd0 || e !== 1'b1 || lat !== 33) begin
      n_fail++; $display("FAIL reserved_op: got res=%h err=%b lat=%0d, want 0 1 33", r, e, lat);
    end
    run_op(2'd0, 32'd9, 32'd0, r, e, lat, ok);
    n_tests++;
    if (!ok || r !== 32'd4 || e !== 1'b0) begin
      n_fail++; $display("FAIL err_clears: got res=%h err=%b, want 4 0", r, e);
    end
  endtask

  task automatic test_backpressure();
    int w = 0; int lat = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd1025; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // stray request during CALC
    in_valid = 1'b1; in_op = 2'd3; in_a = 32'd1;
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL calc_ready: got ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_result !== 32'd11 || out_err !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold[%0d]: got valid=%b res=%h err=%b ready=%b busy=%b, want 1 0000000b 0 0 1",
                 k, out_valid, out_result, out_err, in_ready, busy);
      end
      in_valid = (k == 3); in_op = 2'd2; in_a = 32'd50; in_b = 32'd5;
      @(posedge clk); #1;
    end
    // result handshake and new request on the same edge
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd17; in_b = 32'd0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL handshake_no_accept: got ready=%b valid=%b busy=%b, want 1 0 0",
                         in_ready, out_valid, busy);
    end
    @(posedge clk); #1;   // accepted here from IDLE
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (out_result !== 32'd5 || out_err !== 1'b0 || lat !== 33) begin
      n_fail++; $display("FAIL after_backpressure: got res=%h err=%b lat=%0d, want 5 0 33",
                         out_result, out_err, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int w = 0; int seen = 0;
    logic [31:0] r; logic e; int lat; bit ok;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'h0001_0000; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state: got ready=%b valid=%b busy=%b, want 0 0 0",
                         in_ready, out_valid, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abandoned_op_valid: out_valid seen %0d cycles, want 0", seen);
    end
    run_op(2'd0, 32'd17, 32'd0, r, e, lat, ok);
    n_tests++;
    if (!ok || r !== 32'd5 || e !== 1'b0 || lat !== 33) begin
      n_fail++; $display("FAIL post_reset_clog2: got res=%h err=%b lat=%0d, want 5 0 33", r, e, lat);
    end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [31:0] a, b, r, er; logic e, ee; int lat; bit ok;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom >> $urandom_range(0, 31);
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      model(op, a, b, er, ee);
      run_op(op, a, b, r, e, lat, ok);
      n_tests++;
      if (!ok || r !== er || e !== ee || lat !== 33) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h err=%b lat=%0d, want res=%h err=%b lat=33",
                 i, op, a, b, r, e, lat, er, ee);
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0] as [3]; logic [7:0] bs [3]; logic [1:0] ops [3];
    logic [7:0] er [3]; logic ee [3];
    int w, lat;
    ops = '{2, 2, 0}; as = '{255, 255, 255}; bs = '{16, 0, 0};
    er  = '{16, 8'hFF, 8}; ee = '{0, 1, 0};
    rst8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (!in_ready8 && w < 100) begin @(posedge clk); #1; w++; end
      in_valid8 = 1'b1; in_op8 = ops[i]; in_a8 = as[i]; in_b8 = bs[i];
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
      n_tests++;
      if (out_result8 !== er[i] || out_err8 !== ee[i] || lat !== 9) begin
        n_fail++;
        $display("FAIL w8[%0d] op=%0d a=%0d b=%0d: got res=%0d err=%b lat=%0d, want res=%0d err=%b lat=9",
                 i, ops[i], as[i], bs[i], out_result8, out_err8, lat, er[i], ee[i]);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
